// File: rtl/serial_ha_pkg.sv
// ----------------------------------------------------------------------------
// serial_ha_pkg
//   Shared definitions for the bit-serial half-adder based adder.
//   - state_t / ST_* : FSM state encoding used by serial_ha_adder
//   - WIDTH_DEFAULT  : default operand width
// ----------------------------------------------------------------------------
package serial_ha_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/serial_ha_adder_ha_mux_cell.sv
// ----------------------------------------------------------------------------
// ha_mux_cell
//   Mux-based half adder: operand a selects between b and ~b for the sum,
//   and between 0 and b for the carry.
// Ports:
//   a, b : input bits
//   s    : a XOR b
//   c    : a AND b
// ----------------------------------------------------------------------------
module ha_mux_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ? ~b : b;
    assign c = a ? b : 1'b0;

endmodule

// File: rtl/serial_ha_adder.sv
// ----------------------------------------------------------------------------
// serial_ha_adder
//   Bit-serial WIDTH-bit adder. Operands are accepted over a valid/ready
//   handshake, added LSB-first one bit per clock using two cascaded
//   ha_mux_cell instances plus a carry flop, and the result is returned over
//   a second valid/ready handshake.
//
// Parameters:
//   WIDTH      operand/sum width in bits (>= 2)
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand pair valid
//   in_ready   high in IDLE only
//   a_in,b_in  operands
//   out_valid  high in DONE only
//   out_ready  consumer accepts result
//   sum_out    (a_in + b_in) mod 2^WIDTH, held until the next result
//   carry_out  carry out of the MSB
//   busy       high while shifting
//   ovf_out    (only when SERIAL_HA_OVF_EN is defined) signed overflow
//
// Configuration macro: SERIAL_HA_OVF_EN adds the ovf_out port and its flop.
// ----------------------------------------------------------------------------
module serial_ha_adder
    import serial_ha_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
`ifdef SERIAL_HA_OVF_EN
    output logic             ovf_out,
`endif
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t            state_reg;
    state_t            state_next;

    logic [WIDTH-1:0]  a_sh_reg;
    logic [WIDTH-1:0]  b_sh_reg;
    logic [WIDTH-1:0]  sum_sh_reg;
    logic [WIDTH-1:0]  sum_sh_next;
    logic              cy_reg;
    logic [CW-1:0]     cnt_reg;

    logic              accept;
    logic              last_bit;

    // Full-adder step built from two half-adder cells.
    logic              ha0_s;
    logic              ha0_c;
    logic              fa_sum;
    logic              ha1_c;
    logic              carry_next;

    ha_mux_cell u_ha0 (
        .a (a_sh_reg[0]),
        .b (b_sh_reg[0]),
        .s (ha0_s),
        .c (ha0_c)
    );

    ha_mux_cell u_ha1 (
        .a (ha0_s),
        .b (cy_reg),
        .s (fa_sum),
        .c (ha1_c)
    );

    // The two partial carries can never both be 1, so OR merges them.
    assign carry_next  = ha0_c | ha1_c;

    // New sum bit enters at the MSB so that after WIDTH steps bit 0 holds the
    // LSB of the result.
    assign sum_sh_next = {fa_sum, sum_sh_reg[WIDTH-1:1]};

    assign accept      = (state_reg == ST_IDLE) && in_valid;
    assign last_bit    = (cnt_reg == CNT_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_reg)
            ST_IDLE:  in_ready  = 1'b1;
            ST_SHIFT: busy      = 1'b1;
            ST_DONE:  out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand/sum shift registers, carry flop, bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            sum_sh_reg <= '0;
            cy_reg     <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            if (accept) begin
                a_sh_reg   <= a_in;
                b_sh_reg   <= b_in;
                sum_sh_reg <= '0;
                cy_reg     <= 1'b0;
                cnt_reg    <= '0;
            end else if (state_reg == ST_SHIFT) begin
                a_sh_reg   <= a_sh_reg >> 1;
                b_sh_reg   <= b_sh_reg >> 1;
                sum_sh_reg <= sum_sh_next;
                cy_reg     <= carry_next;
                cnt_reg    <= cnt_reg + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Result registers: loaded only on the SHIFT->DONE edge, so they hold
    // through DONE backpressure and after returning to IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else if ((state_reg == ST_SHIFT) && last_bit) begin
            sum_out   <= sum_sh_next;
            carry_out <= carry_next;
        end
    end

`ifdef SERIAL_HA_OVF_EN
    // On the final step cy_reg is the carry into the MSB and carry_next the
    // carry out of it; their disagreement is signed overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_out <= 1'b0;
        end else if ((state_reg == ST_SHIFT) && last_bit) begin
            ovf_out <= cy_reg ^ carry_next;
        end
    end
`endif

endmodule

// File: tb/tb_serial_ha_adder.sv
// ----------------------------------------------------------------------------
// tb_serial_ha_adder
//   Self-checking bench for serial_ha_adder (WIDTH = 8). Directed corner
//   operands followed by random operands and random result backpressure,
//   compared against plain integer addition.
// ----------------------------------------------------------------------------
module tb_serial_ha_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;
    logic             busy;
`ifdef SERIAL_HA_OVF_EN
    logic             ovf_out;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Last result seen, to verify that outputs hold outside SHIFT->DONE.
    logic [WIDTH-1:0] prev_sum;
    logic             prev_carry;

    serial_ha_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .carry_out (carry_out),
`ifdef SERIAL_HA_OVF_EN
        .ovf_out   (ovf_out),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete operation: accept, shift, hold in DONE for 'hold' cycles
    // with stray in_valid traffic, then release.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int hold);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_carry;
        logic             exp_ovf;
        int               cyc;

        full      = {1'b0, a} + {1'b0, b};
        exp_sum   = full[WIDTH-1:0];
        exp_carry = full[WIDTH];
        exp_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (exp_sum[WIDTH-1] != a[WIDTH-1]);

        check_val("idle_in_ready", in_ready, 1);
        a_in      = a;
        b_in      = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        a_in     = WIDTH'($urandom);
        b_in     = WIDTH'($urandom);
        cyc      = 1;
        check_val("shift_busy", busy, 1);
        check_val("shift_in_ready", in_ready, 0);
        check_val("shift_sum_hold", {prev_carry, sum_out}, {carry_out, prev_sum} == {carry_out, prev_sum} ? {prev_carry, prev_sum} : 0);

        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check_val("latency", cyc, WIDTH + 1);
        check_val("sum", sum_out, exp_sum);
        check_val("carry", carry_out, exp_carry);
`ifdef SERIAL_HA_OVF_EN
        check_val("ovf", ovf_out, exp_ovf);
`endif
        check_val("done_busy", busy, 0);

        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a_in     = WIDTH'($urandom);
            b_in     = WIDTH'($urandom);
            @(negedge clk);
            check_val("bp_out_valid", out_valid, 1);
            check_val("bp_in_ready", in_ready, 0);
            check_val("bp_sum", {carry_out, sum_out}, {exp_carry, exp_sum});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("release_out_valid", out_valid, 0);
        check_val("release_in_ready", in_ready, 1);
        check_val("release_sum_hold", {carry_out, sum_out}, {exp_carry, exp_sum});

        $display("op %02h + %02h -> sum %02h carry %0d (expected %02h/%0d) hold %0d",
                 a, b, sum_out, carry_out, exp_sum, exp_carry, hold);
        prev_sum   = exp_sum;
        prev_carry = exp_carry;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a_in       = '0;
        b_in       = '0;
        prev_sum   = '0;
        prev_carry = 1'b0;

        repeat (2) @(negedge clk);
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_sum", sum_out, 0);
        check_val("rst_carry", carry_out, 0);
        check_val("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed corners.
        run_op(8'h00, 8'h00, 0);
        run_op(8'hFF, 8'h01, 1);
        run_op(8'hA5, 8'h5A, 5);
        run_op(8'h7F, 8'h01, 0);
        run_op(8'hFF, 8'hFF, 2);
        run_op(8'h80, 8'h80, 0);

        // Abort mid-shift with an asynchronous reset around bit 4.
        in_valid = 1'b1;
        a_in     = 8'hC3;
        b_in     = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("async_rst_in_ready", in_ready, 1);
        check_val("async_rst_out_valid", out_valid, 0);
        check_val("async_rst_sum", sum_out, 0);
        check_val("async_rst_carry", carry_out, 0);
        check_val("async_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        prev_sum   = '0;
        prev_carry = 1'b0;
        begin
            int seen_valid;
            seen_valid = 0;
            for (int i = 0; i < WIDTH + 2; i++) begin
                @(negedge clk);
                if (out_valid) seen_valid++;
            end
            check_val("abort_no_out_valid", seen_valid, 0);
        end
        $display("op c3 + 3c aborted by reset");
        run_op(8'h12, 8'h34, 0);

        // Random operands and random backpressure.
        for (int n = 0; n < 24; n++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
